id_stage: RTL

Instruction-decode stage of the 16-bit, 8-register pipelined core. It sits directly upstream of the execute stage and alongside the register file.
- Drives the register file read addresses from the incoming instruction.
- Decodes opcode and fields into control signals.
- Detects load-use hazards and inserts bubbles.
- Owns the ID/EX pipeline register, with valid/ready handshakes on both sides.

---
 rtl/core_pkg.sv | 38 +++
 rtl/id_decoder.sv | 68 ++++++
 rtl/id_stage.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit, 8-register pipelined core:
// opcodes, instruction field positions and the decoded control bundle.
package core_pkg;

    localparam int XLEN    = 16;
    localparam int RADDR_W = 3;

    localparam logic [3:0] OP_RTYPE = 4'd0;
    localparam logic [3:0] OP_ADDI  = 4'd1;
    localparam logic [3:0] OP_LW    = 4'd2;
    localparam logic [3:0] OP_SW    = 4'd3;
    localparam logic [3:0] OP_BEQ   = 4'd4;

    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int RS_HI  = 11;
    localparam int RS_LO  = 9;
    localparam int RT_HI  = 8;
    localparam int RT_LO  = 6;
    localparam int RD_HI  = 5;
    localparam int RD_LO  = 3;
    localparam int FN_HI  = 2;
    localparam int FN_LO  = 0;
    localparam int IMM_HI = 5;

    typedef struct packed {
        logic reg_wr_en;
        logic mem_rd;
        logic mem_wr;
        logic alu_imm;
        logic branch;
    } ctrl_t;

    function automatic logic [XLEN-1:0] sext6(input logic [IMM_HI:0] v);
        return {{(XLEN-IMM_HI-1){v[IMM_HI]}}, v};
    endfunction

endpackage

// File: rtl/id_decoder.sv
// Combinational instruction decoder: control bundle, destination register,
// which source fields are actually read, and the sign-extended immediate.
module id_decoder
    import core_pkg::*;
(
    input  logic [XLEN-1:0]    i_instr,
    output ctrl_t              o_ctrl,
    output logic [RADDR_W-1:0] o_dest,
    output logic               o_rs_used,
    output logic               o_rt_used,
    output logic [XLEN-1:0]    o_imm
);

    logic               w_has_dest;
    logic [RADDR_W-1:0] w_rt;
    logic [RADDR_W-1:0] w_rd;

    assign w_rt  = i_instr[RT_HI:RT_LO];
    assign w_rd  = i_instr[RD_HI:RD_LO];
    assign o_imm = sext6(i_instr[IMM_HI:0]);

    // Opcode decode; unknown opcodes fall through as a NOP with no sources.
    always_comb begin
        o_ctrl     = '0;
        o_dest     = {RADDR_W{1'b0}};
        w_has_dest = 1'b0;
        o_rs_used  = 1'b0;
        o_rt_used  = 1'b0;
        case (i_instr[OP_HI:OP_LO])
            OP_RTYPE: begin
                w_has_dest = 1'b1;
                o_dest     = w_rd;
                o_rs_used  = 1'b1;
                o_rt_used  = 1'b1;
            end
            OP_ADDI: begin
                w_has_dest     = 1'b1;
                o_dest         = w_rt;
                o_rs_used      = 1'b1;
                o_ctrl.alu_imm = 1'b1;
            end
            OP_LW: begin
                w_has_dest     = 1'b1;
                o_dest         = w_rt;
                o_rs_used      = 1'b1;
                o_ctrl.mem_rd  = 1'b1;
                o_ctrl.alu_imm = 1'b1;
            end
            OP_SW: begin
                o_rs_used      = 1'b1;
                o_rt_used      = 1'b1;
                o_ctrl.mem_wr  = 1'b1;
                o_ctrl.alu_imm = 1'b1;
            end
            OP_BEQ: begin
                o_rs_used     = 1'b1;
                o_rt_used     = 1'b1;
                o_ctrl.branch = 1'b1;
            end
            default: begin
                o_ctrl = '0;
            end
        endcase
        // r0 is hardwired to zero, so writes to it are suppressed here.
        o_ctrl.reg_wr_en = w_has_dest & (o_dest != {RADDR_W{1'b0}});
    end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: register file addressing, load-use bubble
// insertion and the ID/EX pipeline register with valid/ready handshakes.
module id_stage
    import core_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_valid,
    input  logic [XLEN-1:0]    if_instr,
    input  logic [XLEN-1:0]    if_pc,
    output logic               id_ready,
    output logic [RADDR_W-1:0] rf_rd_addr_1,
    output logic [RADDR_W-1:0] rf_rd_addr_2,
    input  logic [XLEN-1:0]    rf_rd_data_1,
    input  logic [XLEN-1:0]    rf_rd_data_2,
    input  logic               ex_ready,
    input  logic               flush,
    output logic               idex_valid,
    output logic [XLEN-1:0]    idex_pc,
    output logic [3:0]         idex_op,
    output logic [2:0]         idex_funct,
    output logic [RADDR_W-1:0] idex_rs,
    output logic [RADDR_W-1:0] idex_rt,
    output logic [XLEN-1:0]    idex_rs_data,
    output logic [XLEN-1:0]    idex_rt_data,
    output logic [XLEN-1:0]    idex_imm,
    output logic [RADDR_W-1:0] idex_dest,
    output logic               idex_reg_wr_en,
    output logic               idex_mem_rd,
    output logic               idex_mem_wr,
    output logic               idex_alu_imm,
    output logic               idex_branch,
    output logic [CNT_W-1:0]   stall_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    ctrl_t              w_ctrl;
    logic [RADDR_W-1:0] w_dest;
    logic               w_rs_used;
    logic               w_rt_used;
    logic [XLEN-1:0]    w_imm;
    logic [RADDR_W-1:0] w_rs;
    logic [RADDR_W-1:0] w_rt;
    logic               w_adv;
    logic               w_haz;

    logic               r_valid;
    logic [XLEN-1:0]    r_pc;
    logic [3:0]         r_op;
    logic [2:0]         r_funct;
    logic [RADDR_W-1:0] r_rs;
    logic [RADDR_W-1:0] r_rt;
    logic [XLEN-1:0]    r_rs_data;
    logic [XLEN-1:0]    r_rt_data;
    logic [XLEN-1:0]    r_imm;
    logic [RADDR_W-1:0] r_dest;
    ctrl_t              r_ctrl;
    logic [CNT_W-1:0]   r_stall_count;

    id_decoder u_dec (
        .i_instr   (if_instr),
        .o_ctrl    (w_ctrl),
        .o_dest    (w_dest),
        .o_rs_used (w_rs_used),
        .o_rt_used (w_rt_used),
        .o_imm     (w_imm)
    );

    assign w_rs         = if_instr[RS_HI:RS_LO];
    assign w_rt         = if_instr[RT_HI:RT_LO];
    assign rf_rd_addr_1 = w_rs;
    assign rf_rd_addr_2 = w_rt;

    assign w_adv = ~r_valid | ex_ready;
    // Only fields the incoming instruction actually reads can create a hazard.
    assign w_haz = if_valid & r_valid & r_ctrl.mem_rd & (r_dest != {RADDR_W{1'b0}}) &
                   ((w_rs_used & (w_rs == r_dest)) | (w_rt_used & (w_rt == r_dest)));
    assign id_ready = flush | (w_adv & ~w_haz);

    // ID/EX register and bubble counter; flush beats hazard beats load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid       <= 1'b0;
            r_pc          <= {XLEN{1'b0}};
            r_op          <= 4'd0;
            r_funct       <= 3'd0;
            r_rs          <= {RADDR_W{1'b0}};
            r_rt          <= {RADDR_W{1'b0}};
            r_rs_data     <= {XLEN{1'b0}};
            r_rt_data     <= {XLEN{1'b0}};
            r_imm         <= {XLEN{1'b0}};
            r_dest        <= {RADDR_W{1'b0}};
            r_ctrl        <= '0;
            r_stall_count <= {CNT_W{1'b0}};
        end else if (flush) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (w_adv && w_haz) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            if (r_stall_count != {CNT_W{1'b1}}) begin
                r_stall_count <= r_stall_count + CNT_ONE;
            end
        end else if (w_adv && if_valid) begin
            r_valid   <= 1'b1;
            r_pc      <= if_pc;
            r_op      <= if_instr[OP_HI:OP_LO];
            r_funct   <= if_instr[FN_HI:FN_LO];
            r_rs      <= w_rs;
            r_rt      <= w_rt;
            r_rs_data <= rf_rd_data_1;
            r_rt_data <= rf_rd_data_2;
            r_imm     <= w_imm;
            r_dest    <= w_dest;
            r_ctrl    <= w_ctrl;
        end else if (w_adv) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else begin
            r_valid <= r_valid;
        end
    end

    assign idex_valid     = r_valid;
    assign idex_pc        = r_pc;
    assign idex_op        = r_op;
    assign idex_funct     = r_funct;
    assign idex_rs        = r_rs;
    assign idex_rt        = r_rt;
    assign idex_rs_data   = r_rs_data;
    assign idex_rt_data   = r_rt_data;
    assign idex_imm       = r_imm;
    assign idex_dest      = r_dest;
    assign idex_reg_wr_en = r_ctrl.reg_wr_en;
    assign idex_mem_rd    = r_ctrl.mem_rd;
    assign idex_mem_wr    = r_ctrl.mem_wr;
    assign idex_alu_imm   = r_ctrl.alu_imm;
    assign idex_branch    = r_ctrl.branch;
    assign stall_count    = r_stall_count;

endmodule
